// File: rtl/harvard_sysram_ctrl_v2_pkg.sv
// Shared XT bus types for the system RAM controller.
// Width codes, FSM states and byte-lane helpers.
package harvard_sysram_ctrl_v2_pkg;

  typedef struct packed {
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [1:0]  write_width;
  } hb_slave_t;

  typedef struct packed {
    logic ren;
    logic wen;
  } sel_t;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } width_e;

  typedef enum logic [1:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_HI
  } ram_fsm_e;

  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (width_e'(w))
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] n);
    case (n)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] byte_mask(input logic [2:0] n);
    case (n)
      3'd1:    return 32'h0000_00FF;
      3'd2:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic crosses(
    input logic [1:0] off,
    input logic [2:0] n
  );
    return ({2'b00, off} + {1'b0, n}) > 4'd4;
  endfunction

  function automatic logic [31:0] rotl_bytes(
    input logic [31:0] w,
    input logic [1:0]  off
  );
    case (off)
      2'd0:    return w;
      2'd1:    return {w[23:0], w[31:24]};
      2'd2:    return {w[15:0], w[31:16]};
      default: return {w[7:0], w[31:8]};
    endcase
  endfunction

endpackage

// File: rtl/harvard_sysram_ctrl_v2_byte_bank.sv
// Simple-dual-port RAM built from four 8-bit lanes.
// Byte-enabled write, registered read-first output.
module sysram_byte_bank #(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  logic [7:0] rd_q [4];

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we && be[l]) begin
        mem[waddr] <= wdata[8*l +: 8];
      end
      if (re) begin
        rd_q[l] <= mem[raddr];
      end
    end
  end

  assign rdata = {rd_q[3], rd_q[2], rd_q[1], rd_q[0]};

endmodule

// File: rtl/harvard_sysram_ctrl_v2.sv
// System RAM bus interface: byte-addressed data RAM with split
// misaligned accesses, word instruction RAM with fetch/HB arbitration.
module harvard_sysram_ctrl_v2
  import harvard_sysram_ctrl_v2_pkg::*;
#(
  parameter int          DATA_RAM_DEPTH   = 512,
  parameter int          INST_RAM_DEPTH   = 512,
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter logic [31:0] RESET_INST       = 32'h0000_0013
) (
  input  logic        hb_clk,
  input  logic        hb_rst,
  input  logic        inst_fetch_clk_en,
  input  hb_slave_t   xt_hb,
  input  sel_t        ram_data_sel,
  input  sel_t        ram_inst_sel,
  input  logic [1:0]  data_read_width,
  output logic [31:0] ram_data_rdata,
  output logic        ram_data_read_finish,
  output logic        ram_data_write_finish,
  output logic        ram_data_err,
  input  logic [31:0] inst_fetch_addr,
  output logic [31:0] inst_fetch,
  output logic [31:0] ram_inst_rdata,
  output logic        ram_inst_read_finish,
  output logic        ram_inst_write_finish
);

  localparam int DAW = $clog2(DATA_RAM_DEPTH);
  localparam int IAW = $clog2(INST_RAM_DEPTH);

  logic unused_bits;
  assign unused_bits = ^{xt_hb.raddr, xt_hb.waddr, inst_fetch_addr};

  // data RAM ports
  logic           d_we;
  logic [3:0]     d_be;
  logic [DAW-1:0] d_waddr;
  logic           d_re;
  logic [DAW-1:0] d_raddr;
  logic [31:0]    d_dout;

  sysram_byte_bank #(.DEPTH(DATA_RAM_DEPTH)) u_data_ram (
    .clk   (hb_clk),
    .we    (d_we),
    .be    (d_be),
    .waddr (d_waddr),
    .wdata (rotl_bytes(xt_hb.wdata, xt_hb.waddr[1:0])),
    .re    (d_re),
    .raddr (d_raddr),
    .rdata (d_dout)
  );

  // read FSM
  ram_fsm_e       rd_st_q, rd_st_d;
  logic [1:0]     rd_off_q, rd_off_d;
  logic [2:0]     rd_n_q, rd_n_d;
  logic [DAW-1:0] rd_idx_q, rd_idx_d;
  logic [31:0]    rd_lo_q, rd_lo_d;
  logic           rd_pend_q, rd_pend_d;
  logic           rd_err_q, rd_err_d;
  logic [31:0]    rd_hold_q, rd_hold_d;

  logic [1:0]     rd_off;
  logic [2:0]     rd_n;
  logic [DAW-1:0] rd_idx;
  logic           rd_cross;
  logic [4:0]     lo_sh;
  logic [5:0]     hi_sh;
  logic [31:0]    rd_word;
  logic           rd_fin;

  assign rd_off   = xt_hb.raddr[1:0];
  assign rd_n     = width_bytes(data_read_width);
  assign rd_idx   = xt_hb.raddr[DAW+1:2];
  assign rd_cross = crosses(rd_off, rd_n);
  assign lo_sh    = {rd_off_q, 3'b000};
  assign hi_sh    = 6'd32 - {1'b0, lo_sh};

  always_comb begin
    rd_st_d   = rd_st_q;
    rd_off_d  = rd_off_q;
    rd_n_d    = rd_n_q;
    rd_idx_d  = rd_idx_q;
    rd_lo_d   = rd_lo_q;
    rd_pend_d = 1'b0;
    rd_err_d  = 1'b0;
    rd_hold_d = rd_hold_q;
    d_re      = 1'b0;
    d_raddr   = rd_idx;
    rd_word   = '0;
    rd_fin    = 1'b0;
    unique case (rd_st_q)
      IDLE: begin
        if (rd_pend_q) begin
          rd_fin = 1'b1;
          if (!rd_err_q) begin
            rd_word = (d_dout >> lo_sh) & byte_mask(rd_n_q);
          end
        end else if (ram_data_sel.ren) begin
          rd_off_d = rd_off;
          rd_n_d   = rd_n;
          rd_idx_d = rd_idx;
          if (rd_cross && !ALLOW_MISALIGNED) begin
            rd_pend_d = 1'b1;
            rd_err_d  = 1'b1;
          end else if (rd_cross) begin
            d_re    = 1'b1;
            rd_st_d = RD_LO;
          end else begin
            d_re      = 1'b1;
            rd_pend_d = 1'b1;
          end
        end
      end
      RD_LO: begin
        rd_lo_d = d_dout >> lo_sh;
        d_re    = 1'b1;
        d_raddr = rd_idx_q + DAW'(1);
        rd_st_d = RD_HI;
      end
      RD_HI: begin
        rd_fin  = 1'b1;
        rd_word = (rd_lo_q | (d_dout << hi_sh)) & byte_mask(rd_n_q);
        rd_st_d = IDLE;
      end
      default: rd_st_d = IDLE;
    endcase
    if (rd_fin) begin
      rd_hold_d = rd_word;
    end
  end

  assign ram_data_rdata       = rd_fin ? rd_word : rd_hold_q;
  assign ram_data_read_finish = rd_fin;

  // write FSM; the bus holds address/data, so WR_HI recomputes lanes
  ram_fsm_e       wr_st_q, wr_st_d;
  logic           wr_err_q, wr_err_d;
  logic [2:0]     wr_n;
  logic [DAW-1:0] wr_idx;
  logic           wr_cross;
  logic [7:0]     be_full;
  logic           wr_fin;

  assign wr_n     = width_bytes(xt_hb.write_width);
  assign wr_idx   = xt_hb.waddr[DAW+1:2];
  assign wr_cross = crosses(xt_hb.waddr[1:0], wr_n);
  assign be_full  = {4'b0000, lane_mask(wr_n)} << xt_hb.waddr[1:0];

  always_comb begin
    wr_st_d  = wr_st_q;
    wr_err_d = 1'b0;
    d_we     = 1'b0;
    d_be     = 4'b0000;
    d_waddr  = wr_idx;
    wr_fin   = 1'b0;
    if (!hb_rst) begin
      unique case (wr_st_q)
        IDLE: begin
          if (ram_data_sel.wen) begin
            if (wr_cross && !ALLOW_MISALIGNED) begin
              wr_fin   = 1'b1;
              wr_err_d = 1'b1;
            end else if (wr_cross) begin
              d_we    = 1'b1;
              d_be    = be_full[3:0];
              wr_st_d = WR_HI;
            end else begin
              d_we   = 1'b1;
              d_be   = be_full[3:0];
              wr_fin = 1'b1;
            end
          end
        end
        WR_HI: begin
          d_we    = 1'b1;
          d_be    = be_full[7:4];
          d_waddr = wr_idx + DAW'(1);
          wr_fin  = 1'b1;
          wr_st_d = IDLE;
        end
        default: wr_st_d = IDLE;
      endcase
    end
  end

  assign ram_data_write_finish = wr_fin;
  assign ram_data_err          = rd_err_q | wr_err_q;

  // instruction RAM: fetch owns the read port while enabled
  logic           i_we;
  logic           i_re;
  logic [IAW-1:0] i_raddr;
  logic [31:0]    i_dout;
  logic           hb_grant;
  logic           fetch_pend_q, fetch_pend_d;
  logic           hb_pend_q, hb_pend_d;
  logic [31:0]    fetch_hold_q, fetch_hold_d;
  logic [31:0]    inst_hold_q, inst_hold_d;

  assign i_we = ram_inst_sel.wen && !hb_rst;

  sysram_byte_bank #(.DEPTH(INST_RAM_DEPTH)) u_inst_ram (
    .clk   (hb_clk),
    .we    (i_we),
    .be    (4'b1111),
    .waddr (xt_hb.waddr[IAW+1:2]),
    .wdata (xt_hb.wdata),
    .re    (i_re),
    .raddr (i_raddr),
    .rdata (i_dout)
  );

  always_comb begin
    hb_grant     = !inst_fetch_clk_en && ram_inst_sel.ren && !hb_pend_q;
    i_re         = inst_fetch_clk_en || hb_grant;
    i_raddr      = inst_fetch_clk_en ? inst_fetch_addr[IAW+1:2]
                                     : xt_hb.raddr[IAW+1:2];
    fetch_pend_d = inst_fetch_clk_en;
    hb_pend_d    = hb_grant;
    inst_fetch   = fetch_pend_q ? i_dout : fetch_hold_q;
    fetch_hold_d = inst_fetch;
    ram_inst_rdata = hb_pend_q ? i_dout : inst_hold_q;
    inst_hold_d    = ram_inst_rdata;
  end

  assign ram_inst_read_finish  = hb_pend_q;
  assign ram_inst_write_finish = 1'b1;

  always_ff @(posedge hb_clk) begin
    if (hb_rst) begin
      rd_st_q      <= IDLE;
      rd_off_q     <= '0;
      rd_n_q       <= '0;
      rd_idx_q     <= '0;
      rd_lo_q      <= '0;
      rd_pend_q    <= 1'b0;
      rd_err_q     <= 1'b0;
      rd_hold_q    <= '0;
      wr_st_q      <= IDLE;
      wr_err_q     <= 1'b0;
      fetch_pend_q <= 1'b0;
      hb_pend_q    <= 1'b0;
      fetch_hold_q <= RESET_INST;
      inst_hold_q  <= '0;
    end else begin
      rd_st_q      <= rd_st_d;
      rd_off_q     <= rd_off_d;
      rd_n_q       <= rd_n_d;
      rd_idx_q     <= rd_idx_d;
      rd_lo_q      <= rd_lo_d;
      rd_pend_q    <= rd_pend_d;
      rd_err_q     <= rd_err_d;
      rd_hold_q    <= rd_hold_d;
      wr_st_q      <= wr_st_d;
      wr_err_q     <= wr_err_d;
      fetch_pend_q <= fetch_pend_d;
      hb_pend_q    <= hb_pend_d;
      fetch_hold_q <= fetch_hold_d;
      inst_hold_q  <= inst_hold_d;
    end
  end

endmodule

// File: tb/tb_harvard_sysram_ctrl_v2.sv
// Directed bench for harvard_sysram_ctrl_v2: aligned, sub-word,
// split, wrap, rejected misaligned, inst arbitration, reset.
module tb_harvard_sysram_ctrl_v2;
  import harvard_sysram_ctrl_v2_pkg::*;

  logic        hb_clk = 1'b0;
  logic        hb_rst;
  logic        fetch_en;
  hb_slave_t   xt_hb;
  sel_t        dsel, isel, nsel;
  logic [1:0]  rwidth;
  logic [31:0] fetch_addr;

  logic [31:0] d_rdata, d_ifetch, d_irdata;
  logic        d_rf, d_wf, d_err, d_irf, d_iwf;
  logic [31:0] n_rdata, n_ifetch, n_irdata;
  logic        n_rf, n_wf, n_err, n_irf, n_iwf;

  int checks = 0;
  int failures = 0;

  always #5 hb_clk = ~hb_clk;

  harvard_sysram_ctrl_v2 dut (
    .hb_clk                (hb_clk),
    .hb_rst                (hb_rst),
    .inst_fetch_clk_en     (fetch_en),
    .xt_hb                 (xt_hb),
    .ram_data_sel          (dsel),
    .ram_inst_sel          (isel),
    .data_read_width       (rwidth),
    .ram_data_rdata        (d_rdata),
    .ram_data_read_finish  (d_rf),
    .ram_data_write_finish (d_wf),
    .ram_data_err          (d_err),
    .inst_fetch_addr       (fetch_addr),
    .inst_fetch            (d_ifetch),
    .ram_inst_rdata        (d_irdata),
    .ram_inst_read_finish  (d_irf),
    .ram_inst_write_finish (d_iwf)
  );

  harvard_sysram_ctrl_v2 #(.ALLOW_MISALIGNED(1'b0)) dut_na (
    .hb_clk                (hb_clk),
    .hb_rst                (hb_rst),
    .inst_fetch_clk_en     (1'b0),
    .xt_hb                 (xt_hb),
    .ram_data_sel          (nsel),
    .ram_inst_sel          (2'b00),
    .data_read_width       (rwidth),
    .ram_data_rdata        (n_rdata),
    .ram_data_read_finish  (n_rf),
    .ram_data_write_finish (n_wf),
    .ram_data_err          (n_err),
    .inst_fetch_addr       (32'h0),
    .inst_fetch            (n_ifetch),
    .ram_inst_rdata        (n_irdata),
    .ram_inst_read_finish  (n_irf),
    .ram_inst_write_finish (n_iwf)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge hb_clk);
    #1;
  endtask

  task automatic wr(input bit na, input logic [31:0] a,
                    input logic [31:0] d, input logic [1:0] w,
                    output int cyc, output logic err);
    bit done;
    xt_hb.waddr = a;
    xt_hb.wdata = d;
    xt_hb.write_width = w;
    if (na) nsel.wen = 1'b1;
    else dsel.wen = 1'b1;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 8) begin
      @(negedge hb_clk);
      cyc++;
      done = na ? n_wf : d_wf;
      step();
    end
    dsel.wen = 1'b0;
    nsel.wen = 1'b0;
    @(negedge hb_clk);
    err = na ? n_err : d_err;
    step();
  endtask

  task automatic rd(input bit na, input logic [31:0] a,
                    input logic [1:0] w, output logic [31:0] data,
                    output int cyc, output logic err);
    bit done;
    xt_hb.raddr = a;
    rwidth = w;
    if (na) nsel.ren = 1'b1;
    else dsel.ren = 1'b1;
    cyc = 0;
    done = 1'b0;
    data = 'x;
    err = 1'bx;
    while (!done && cyc < 8) begin
      @(negedge hb_clk);
      cyc++;
      done = na ? n_rf : d_rf;
      if (done) begin
        data = na ? n_rdata : d_rdata;
        err = na ? n_err : d_err;
      end
      step();
    end
    dsel.ren = 1'b0;
    nsel.ren = 1'b0;
  endtask

  int          cyc;
  logic        err;
  logic [31:0] data;

  initial begin
    hb_rst = 1'b1;
    fetch_en = 1'b0;
    xt_hb = '0;
    dsel = '0;
    isel = '0;
    nsel = '0;
    rwidth = 2'b10;
    fetch_addr = '0;
    repeat (3) step();
    hb_rst = 1'b0;
    @(negedge hb_clk);
    chk("rst_rdata", d_rdata, 32'h0);
    chk("rst_rfin", {31'b0, d_rf}, 32'h0);
    chk("rst_err", {31'b0, d_err}, 32'h0);
    chk("rst_ifetch", d_ifetch, 32'h0000_0013);
    chk("rst_irdata", d_irdata, 32'h0);
    chk("rst_irfin", {31'b0, d_irf}, 32'h0);
    step();

    wr(0, 32'h10, 32'hDEAD_BEEF, 2'b10, cyc, err);
    chk("sw10_cyc", cyc, 1);
    chk("sw10_err", {31'b0, err}, 32'h0);
    rd(0, 32'h10, 2'b10, data, cyc, err);
    chk("lw10_cyc", cyc, 2);
    chk("lw10_data", data, 32'hDEAD_BEEF);

    wr(0, 32'h13, 32'h0000_00AA, 2'b00, cyc, err);
    chk("sb13_cyc", cyc, 1);
    rd(0, 32'h13, 2'b00, data, cyc, err);
    chk("lbu13", data, 32'h0000_00AA);
    rd(0, 32'h12, 2'b01, data, cyc, err);
    chk("lhu12", data, 32'h0000_AAAD);

    wr(0, 32'h0E, 32'h1122_3344, 2'b10, cyc, err);
    chk("swx_cyc", cyc, 2);
    rd(0, 32'h0E, 2'b10, data, cyc, err);
    chk("lwx_cyc", cyc, 3);
    chk("lwx_data", data, 32'h1122_3344);
    rd(0, 32'h0E, 2'b01, data, cyc, err);
    chk("lhu0e", data, 32'h0000_3344);
    rd(0, 32'h10, 2'b01, data, cyc, err);
    chk("lhu10", data, 32'h0000_1122);
    rd(0, 32'h10, 2'b11, data, cyc, err);
    chk("lw10_w11", data, 32'hAAAD_1122);

    wr(0, 32'h7FF, 32'h0000_BEEF, 2'b01, cyc, err);
    chk("shwrap_cyc", cyc, 2);
    rd(0, 32'h7FF, 2'b00, data, cyc, err);
    chk("lbu7ff", data, 32'h0000_00EF);
    rd(0, 32'h000, 2'b00, data, cyc, err);
    chk("lbu000", data, 32'h0000_00BE);
    rd(0, 32'h7FF, 2'b01, data, cyc, err);
    chk("lhuwrap", data, 32'h0000_BEEF);
    chk("lhuwrap_cyc", cyc, 3);

    wr(1, 32'h00, 32'h1234_5678, 2'b10, cyc, err);
    chk("na_sw_err", {31'b0, err}, 32'h0);
    rd(1, 32'h01, 2'b10, data, cyc, err);
    chk("na_lw_cyc", cyc, 2);
    chk("na_lw_data", data, 32'h0);
    chk("na_lw_err", {31'b0, err}, 32'h1);
    wr(1, 32'h03, 32'hFFFF_FFFF, 2'b10, cyc, err);
    chk("na_swx_cyc", cyc, 1);
    chk("na_swx_err", {31'b0, err}, 32'h1);
    rd(1, 32'h00, 2'b10, data, cyc, err);
    chk("na_unchanged", data, 32'h1234_5678);
    chk("na_ok_err", {31'b0, err}, 32'h0);

    xt_hb.waddr = 32'h20;
    xt_hb.wdata = 32'hCAFE_F00D;
    isel.wen = 1'b1;
    @(negedge hb_clk);
    chk("iwfin", {31'b0, d_iwf}, 32'h1);
    step();
    xt_hb.waddr = 32'h24;
    xt_hb.wdata = 32'h0BAD_BEEF;
    step();
    isel.wen = 1'b0;
    fetch_en = 1'b1;
    fetch_addr = 32'h24;
    isel.ren = 1'b1;
    xt_hb.raddr = 32'h20;
    @(negedge hb_clk);
    chk("if_pre", d_ifetch, 32'h0000_0013);
    chk("if_fin0", {31'b0, d_irf}, 32'h0);
    step();
    @(negedge hb_clk);
    chk("if_24a", d_ifetch, 32'h0BAD_BEEF);
    chk("if_fin1", {31'b0, d_irf}, 32'h0);
    step();
    fetch_addr = 32'h21;
    @(negedge hb_clk);
    step();
    fetch_addr = 32'h24;
    @(negedge hb_clk);
    chk("if_20", d_ifetch, 32'hCAFE_F00D);
    chk("if_fin2", {31'b0, d_irf}, 32'h0);
    step();
    fetch_en = 1'b0;
    @(negedge hb_clk);
    chk("if_24b", d_ifetch, 32'h0BAD_BEEF);
    chk("if_fin3", {31'b0, d_irf}, 32'h0);
    step();
    @(negedge hb_clk);
    chk("hb_fin", {31'b0, d_irf}, 32'h1);
    chk("hb_rdata", d_irdata, 32'hCAFE_F00D);
    chk("if_held", d_ifetch, 32'h0BAD_BEEF);
    step();
    isel.ren = 1'b0;
    @(negedge hb_clk);
    chk("hb_fin_end", {31'b0, d_irf}, 32'h0);
    chk("hb_rd_hold", d_irdata, 32'hCAFE_F00D);
    step();

    xt_hb.waddr = 32'h0E;
    xt_hb.wdata = 32'h5566_7788;
    xt_hb.write_width = 2'b10;
    dsel.wen = 1'b1;
    @(negedge hb_clk);
    chk("rstw_wf_lo", {31'b0, d_wf}, 32'h0);
    step();
    hb_rst = 1'b1;
    @(negedge hb_clk);
    chk("rstw_wf_hi", {31'b0, d_wf}, 32'h0);
    step();
    hb_rst = 1'b0;
    dsel.wen = 1'b0;
    @(negedge hb_clk);
    chk("rstw_rfin", {31'b0, d_rf}, 32'h0);
    chk("rstw_rdata", d_rdata, 32'h0);
    chk("rstw_ifetch", d_ifetch, 32'h0000_0013);
    step();
    rd(0, 32'h0E, 2'b01, data, cyc, err);
    chk("rstw_lo", data, 32'h0000_7788);
    rd(0, 32'h10, 2'b01, data, cyc, err);
    chk("rstw_hi", data, 32'h0000_1122);
    wr(0, 32'h40, 32'h0102_0304, 2'b10, cyc, err);
    chk("rstw_idle_cyc", cyc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
